// File: rtl/fifo_buf_parity_if.sv
// rtl/fifo_buf_parity_if.sv - producer/consumer bundle for fifo_buf_parity (parity ports under FIFO_PARITY_CHECK_EN)
interface fifo_buf_parity_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
`ifdef FIFO_PARITY_CHECK_EN
    logic                  inj_err;
    logic                  parity_err;
`endif

    // Producer/consumer side: drives requests, observes data and status.
    modport master (
        output push, push_data, pop,
`ifdef FIFO_PARITY_CHECK_EN
        output inj_err,
        input  parity_err,
`endif
        input  pop_data, empty, full, almost_full, count, overflow, underflow
    );

    // FIFO side: accepts requests, presents data and status.
    modport slave (
        input  push, push_data, pop,
`ifdef FIFO_PARITY_CHECK_EN
        input  inj_err,
        output parity_err,
`endif
        output pop_data, empty, full, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_buf_parity.sv
// rtl/fifo_buf_parity.sv - FWFT synchronous FIFO with optional per-entry parity (FIFO_PARITY_CHECK_EN)
module fifo_buf_parity #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int AFULL_LVL  = 3,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_buf_parity_if.slave  bus
);

`ifdef FIFO_PARITY_CHECK_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);

    logic [MEM_WIDTH-1:0]  mem [FIFO_DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q, count_q;
    logic [ADDR_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic                  empty_q, full_q, afull_q;
    logic                  overflow_q, underflow_q;
    logic                  push_acc, pop_acc;
    logic [MEM_WIDTH-1:0]  wr_entry, rd_entry;

    // A push into a full FIFO is still taken when a pop frees the head slot this cycle.
    assign push_acc = bus.push & (~full_q | bus.pop);
    assign pop_acc  = bus.pop & ~empty_q;

    assign rd_entry = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

`ifdef FIFO_PARITY_CHECK_EN
    logic parity_err_q;
    assign wr_entry       = {(^bus.push_data) ^ bus.inj_err, bus.push_data};
    assign bus.parity_err = parity_err_q;
`else
    assign wr_entry = bus.push_data;
`endif

    // Next pointer/occupancy values; status flags are derived from these so they register together.
    always_comb begin
        wr_ptr_nxt = wr_ptr_q;
        rd_ptr_nxt = rd_ptr_q;
        count_nxt  = count_q;
        if (push_acc) wr_ptr_nxt = wr_ptr_q + PTR_ONE;
        if (pop_acc)  rd_ptr_nxt = rd_ptr_q + PTR_ONE;
        case ({push_acc, pop_acc})
            2'b10:   count_nxt = count_q + PTR_ONE;
            2'b01:   count_nxt = count_q - PTR_ONE;
            default: count_nxt = count_q;
        endcase
    end

    // Storage array: written on accepted push, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_entry;
    end

    // Pointers, occupancy, registered status flags and one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            afull_q      <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef FIFO_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_nxt;
            rd_ptr_q     <= rd_ptr_nxt;
            count_q      <= count_nxt;
            empty_q      <= (wr_ptr_nxt == rd_ptr_nxt);
            full_q       <= (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                            (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
            afull_q      <= (count_nxt >= AFULL_CNT);
            overflow_q   <= bus.push & full_q & ~bus.pop;
            underflow_q  <= bus.pop & empty_q;
`ifdef FIFO_PARITY_CHECK_EN
            parity_err_q <= pop_acc & (^rd_entry);
`endif
        end
    end

    assign bus.pop_data    = empty_q ? '0 : rd_entry[DATA_WIDTH-1:0];
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_buf_parity.sv
// tb/tb_fifo_buf_parity.sv - directed self-checking bench for fifo_buf_parity
module tb_fifo_buf_parity;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fifo_buf_parity_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) bif ();

    fifo_buf_parity #(.FIFO_DEPTH(4), .DATA_WIDTH(16), .AFULL_LVL(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill4();
        for (int i = 1; i <= 4; i++) begin
            bif.push      = 1'b1;
            bif.push_data = 16'(i);
            step();
        end
        bif.push = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bif.push      = 1'b0;
        bif.pop       = 1'b0;
        bif.push_data = '0;
`ifdef FIFO_PARITY_CHECK_EN
        bif.inj_err   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(bif.count), 32'd0);
        check("rst_empty", 32'(bif.empty), 32'd1);
        check("rst_full", 32'(bif.full), 32'd0);
        check("rst_afull", 32'(bif.almost_full), 32'd0);
        check("rst_ovf", 32'(bif.overflow), 32'd0);
        check("rst_udf", 32'(bif.underflow), 32'd0);
        check("rst_pop_data", 32'(bif.pop_data), 32'd0);
        rst_n = 1'b1;

        // fill to full, watching almost_full and head
        for (int i = 1; i <= 4; i++) begin
            bif.push      = 1'b1;
            bif.push_data = 16'(i);
            step();
            check("fill_count", 32'(bif.count), 32'(i));
            check("fill_afull", 32'(bif.almost_full), (i >= 3) ? 32'd1 : 32'd0);
            check("fill_head", 32'(bif.pop_data), 32'h0001);
        end
        bif.push = 1'b0;
        check("fill_full", 32'(bif.full), 32'd1);
        check("fill_empty", 32'(bif.empty), 32'd0);

        // drain in order
        bif.pop = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(bif.pop_data), 32'(i));
            step();
        end
        bif.pop = 1'b0;
        check("drain_empty", 32'(bif.empty), 32'd1);
        check("drain_pop_data", 32'(bif.pop_data), 32'd0);
        check("drain_udf", 32'(bif.underflow), 32'd0);

        // overflow: push into full without pop is dropped
        fill4();
        bif.push      = 1'b1;
        bif.push_data = 16'hBEEF;
        step();
        bif.push = 1'b0;
        check("ovf_pulse", 32'(bif.overflow), 32'd1);
        check("ovf_count", 32'(bif.count), 32'd4);
        step();
        check("ovf_clear", 32'(bif.overflow), 32'd0);

        // push+pop on full: write lands in freed slot
        bif.push      = 1'b1;
        bif.pop       = 1'b1;
        bif.push_data = 16'hBEEF;
        step();
        bif.push = 1'b0;
        check("fullpp_count", 32'(bif.count), 32'd4);
        check("fullpp_full", 32'(bif.full), 32'd1);
        check("fullpp_ovf", 32'(bif.overflow), 32'd0);
        check("fullpp_d0", 32'(bif.pop_data), 32'h0002);
        step();
        check("fullpp_d1", 32'(bif.pop_data), 32'h0003);
        step();
        check("fullpp_d2", 32'(bif.pop_data), 32'h0004);
        step();
        check("fullpp_d3", 32'(bif.pop_data), 32'hBEEF);
        step();
        bif.pop = 1'b0;
        check("fullpp_empty", 32'(bif.empty), 32'd1);

        // push+pop on empty: push taken, pop ignored
        bif.push      = 1'b1;
        bif.pop       = 1'b1;
        bif.push_data = 16'h00AA;
        step();
        bif.push = 1'b0;
        bif.pop  = 1'b0;
        check("emptypp_udf", 32'(bif.underflow), 32'd1);
        check("emptypp_count", 32'(bif.count), 32'd1);
        check("emptypp_data", 32'(bif.pop_data), 32'h00AA);
        step();
        check("emptypp_udf_clear", 32'(bif.underflow), 32'd0);
        bif.pop = 1'b1;
        step();
        bif.pop = 1'b0;
        check("emptypp_drain", 32'(bif.empty), 32'd1);

        // steady push/pop stream across pointer wraps
        bif.push      = 1'b1;
        bif.push_data = 16'h0100;
        step();
        for (int i = 0; i < 10; i++) begin
            bif.pop       = 1'b1;
            bif.push_data = 16'(16'h0101 + i);
            check("wrap_data", 32'(bif.pop_data), 32'(16'h0100 + i));
            step();
            check("wrap_count", 32'(bif.count), 32'd1);
            check("wrap_flags", {29'd0, bif.overflow, bif.underflow, bif.full}, 32'd0);
        end
        bif.push = 1'b0;
        check("wrap_last", 32'(bif.pop_data), 32'h010A);
        step();
        bif.pop = 1'b0;
        check("wrap_empty", 32'(bif.empty), 32'd1);

        // async reset mid-operation, next push visible at address 0
        bif.push      = 1'b1;
        bif.push_data = 16'h1111;
        step();
        step();
        bif.push = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(bif.count), 32'd0);
        check("async_rst_empty", 32'(bif.empty), 32'd1);
        step();
        rst_n         = 1'b1;
        bif.push      = 1'b1;
        bif.push_data = 16'h5A5A;
        step();
        bif.push = 1'b0;
        check("post_rst_data", 32'(bif.pop_data), 32'h5A5A);
        check("post_rst_count", 32'(bif.count), 32'd1);
        bif.pop = 1'b1;
        step();
        bif.pop = 1'b0;

`ifdef FIFO_PARITY_CHECK_EN
        // corrupted parity is flagged for one cycle, data still delivered
        bif.push      = 1'b1;
        bif.push_data = 16'h1234;
        bif.inj_err   = 1'b1;
        step();
        bif.push    = 1'b0;
        bif.inj_err = 1'b0;
        bif.pop     = 1'b1;
        check("par_data", 32'(bif.pop_data), 32'h1234);
        step();
        bif.pop = 1'b0;
        check("par_err", 32'(bif.parity_err), 32'd1);
        step();
        check("par_err_clear", 32'(bif.parity_err), 32'd0);
        // clean entry raises nothing
        bif.push      = 1'b1;
        bif.push_data = 16'h1234;
        step();
        bif.push = 1'b0;
        bif.pop  = 1'b1;
        step();
        bif.pop = 1'b0;
        check("par_clean", 32'(bif.parity_err), 32'd0);
`else
        bif.push      = 1'b1;
        bif.push_data = 16'h1234;
        step();
        bif.push = 1'b0;
        bif.pop  = 1'b1;
        check("nopar_data", 32'(bif.pop_data), 32'h1234);
        step();
        bif.pop = 1'b0;
        check("nopar_empty", 32'(bif.empty), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
